// File: rtl/acq_sram_writer.sv
// Acquisition SRAM writer: queues timing bytes from the disc reader in a small FIFO and
// stores them at consecutive SRAM addresses using a multi-cycle write strobe.
module acq_sram_writer #(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WE_CYCLES  = 2
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    input  logic [7:0]            DATA_IN,
    input  logic                  WRITE_IN,
    input  logic                  ADDR_LOAD,
    input  logic [ADDR_WIDTH-1:0] ADDR_LOAD_VAL,
    output logic [ADDR_WIDTH-1:0] SRAM_A,
    output logic [7:0]            SRAM_DQ_OUT,
    output logic                  SRAM_DQ_OE,
    output logic                  SRAM_WE_N,
    output logic [ADDR_WIDTH-1:0] ADDR,
    output logic                  BUSY,
    output logic                  FULL,
    output logic                  OVERRUN
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned WcW  = $clog2(WE_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

    state_e                state_q, state_d;
    logic [WcW-1:0]        strobe_cnt_q, strobe_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  full_q, full_d;
    logic                  overrun_q, overrun_d;

    logic [7:0]            fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;

    logic [ADDR_WIDTH-1:0] sram_a_q, sram_a_d;
    logic [7:0]            sram_dq_q, sram_dq_d;
    logic                  sram_oe_q, sram_oe_d;
    logic                  sram_we_n_q, sram_we_n_d;

    logic                  fifo_empty, fifo_full;
    logic                  push_req, push_ok, pop, at_top, flush, busy;
    logic [7:0]            head_next;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    assign push_req   = WRITE_IN && ENABLE && !full_q;
    assign pop        = (state_q == StHold);
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign at_top     = (addr_q == '1);
    assign flush      = pop && at_top;
    assign busy       = !fifo_empty || (state_q != StIdle);

    // FIFO pointer and count update, including the flush once memory is full
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (flush) begin
            rd_ptr_d = wr_ptr_d;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push_ok && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (!push_ok && pop) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    // Head byte after this edge; bypass DATA_IN when the new head is the byte being pushed now
    always_comb begin
        head_next = fifo_mem[rd_ptr_d];
        if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
            head_next = DATA_IN;
        end
    end

    // Write state machine, address counter, sticky flags and SRAM output next-state
    always_comb begin
        state_d      = state_q;
        strobe_cnt_d = strobe_cnt_q;
        addr_d       = addr_q;
        full_d       = full_q;
        overrun_d    = overrun_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && !full_q) begin
                    state_d = StSetup;
                end
            end
            StSetup: begin
                state_d      = StStrobe;
                strobe_cnt_d = '0;
            end
            StStrobe: begin
                if (strobe_cnt_q == WcW'(WE_CYCLES - 1)) begin
                    state_d = StHold;
                end else begin
                    strobe_cnt_d = strobe_cnt_q + WcW'(1);
                end
            end
            StHold: begin
                if (at_top) begin
                    full_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = (count_d != '0) ? StSetup : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (push_req && fifo_full && !pop) begin
            overrun_d = 1'b1;
        end
        if (ADDR_LOAD && !busy && !ENABLE) begin
            addr_d    = ADDR_LOAD_VAL;
            full_d    = 1'b0;
            overrun_d = 1'b0;
        end

        // Address and data are captured on entry to SETUP and held until the next SETUP
        sram_a_d  = sram_a_q;
        sram_dq_d = sram_dq_q;
        if (state_d == StSetup) begin
            sram_a_d  = addr_d;
            sram_dq_d = head_next;
        end
        sram_we_n_d = (state_d != StStrobe);
        sram_oe_d   = (state_d != StIdle);
    end

    // State, counters, flags and registered SRAM outputs
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q      <= StIdle;
            strobe_cnt_q <= '0;
            addr_q       <= '0;
            full_q       <= 1'b0;
            overrun_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            sram_a_q     <= '0;
            sram_dq_q    <= '0;
            sram_oe_q    <= 1'b0;
            sram_we_n_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            strobe_cnt_q <= strobe_cnt_d;
            addr_q       <= addr_d;
            full_q       <= full_d;
            overrun_q    <= overrun_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            sram_a_q     <= sram_a_d;
            sram_dq_q    <= sram_dq_d;
            sram_oe_q    <= sram_oe_d;
            sram_we_n_q  <= sram_we_n_d;
        end
    end

    // FIFO storage; contents need no reset because the count governs validity
    always_ff @(posedge CLOCK) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= DATA_IN;
        end
    end

    assign SRAM_A      = sram_a_q;
    assign SRAM_DQ_OUT = sram_dq_q;
    assign SRAM_DQ_OE  = sram_oe_q;
    assign SRAM_WE_N   = sram_we_n_q;
    assign ADDR        = addr_q;
    assign BUSY        = busy;
    assign FULL        = full_q;
    assign OVERRUN     = overrun_q;

endmodule

// File: tb/tb_acq_sram_writer.sv
// Directed bench for acq_sram_writer: a default-size instance and a 4-bit-address instance.
module tb_acq_sram_writer;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable, write_in, addr_load;
    logic [7:0]  data_in;
    logic [18:0] addr_load_val;
    logic [18:0] sram_a, addr;
    logic [7:0]  sram_dq;
    logic        sram_oe, sram_we_n, busy, full, overrun;

    logic        en4, w4, ld4;
    logic [7:0]  d4;
    logic [3:0]  ldv4;
    logic [3:0]  sram_a4, addr4;
    logic [7:0]  sram_dq4;
    logic        sram_oe4, sram_we_n4, busy4, full4, overrun4;

    int n_cmp = 0;
    int n_bad = 0;

    // Write log: one entry per falling edge of the write strobe
    logic [18:0] log_a  [64];
    logic [7:0]  log_d  [64];
    int          n_log  = 0;
    logic        we_prev = 1'b1;
    logic [3:0]  log4_a [16];
    logic [7:0]  log4_d [16];
    int          n_log4 = 0;
    logic        we4_prev = 1'b1;

    acq_sram_writer dut (
        .CLOCK(clock), .RESET(reset), .ENABLE(enable), .DATA_IN(data_in),
        .WRITE_IN(write_in), .ADDR_LOAD(addr_load), .ADDR_LOAD_VAL(addr_load_val),
        .SRAM_A(sram_a), .SRAM_DQ_OUT(sram_dq), .SRAM_DQ_OE(sram_oe), .SRAM_WE_N(sram_we_n),
        .ADDR(addr), .BUSY(busy), .FULL(full), .OVERRUN(overrun)
    );

    acq_sram_writer #(.ADDR_WIDTH(4)) dut4 (
        .CLOCK(clock), .RESET(reset), .ENABLE(en4), .DATA_IN(d4),
        .WRITE_IN(w4), .ADDR_LOAD(ld4), .ADDR_LOAD_VAL(ldv4),
        .SRAM_A(sram_a4), .SRAM_DQ_OUT(sram_dq4), .SRAM_DQ_OE(sram_oe4),
        .SRAM_WE_N(sram_we_n4), .ADDR(addr4), .BUSY(busy4), .FULL(full4), .OVERRUN(overrun4)
    );

    always #5 clock = ~clock;

    // Log each write when the strobe first goes low
    always @(negedge clock) begin
        if (we_prev === 1'b1 && sram_we_n === 1'b0 && n_log < 64) begin
            log_a[n_log] = sram_a;
            log_d[n_log] = sram_dq;
            n_log = n_log + 1;
        end
        we_prev = sram_we_n;
        if (we4_prev === 1'b1 && sram_we_n4 === 1'b0 && n_log4 < 16) begin
            log4_a[n_log4] = sram_a4;
            log4_d[n_log4] = sram_dq4;
            n_log4 = n_log4 + 1;
        end
        we4_prev = sram_we_n4;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int base;
        int t;
        logic [7:0] exp2 [5];
        exp2[0] = 8'h01; exp2[1] = 8'h02; exp2[2] = 8'h03; exp2[3] = 8'h04; exp2[4] = 8'h06;

        reset = 1'b1; enable = 1'b0; write_in = 1'b0; addr_load = 1'b0;
        data_in = 8'h00; addr_load_val = '0;
        en4 = 1'b0; w4 = 1'b0; ld4 = 1'b0; d4 = 8'h00; ldv4 = '0;
        tick(2);
        check("rst_we_n", sram_we_n, 1);
        check("rst_oe", sram_oe, 0);
        check("rst_sram_a", sram_a, 0);
        check("rst_dq", sram_dq, 0);
        check("rst_addr", addr, 0);
        check("rst_full", full, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        tick(1);

        // Test 1: single byte at loaded address 0x10
        addr_load = 1'b1; addr_load_val = 19'h10;
        tick(1);
        addr_load = 1'b0;
        check("t1_load", addr, 19'h10);
        enable = 1'b1;
        tick(1);
        data_in = 8'hA5; write_in = 1'b1;            // cycle 0
        tick(1);
        write_in = 1'b0;                              // cycle 1
        check("t1_busy_c1", busy, 1);
        check("t1_we_c1", sram_we_n, 1);
        tick(1);                                      // cycle 2: SETUP
        check("t1_sram_a", sram_a, 19'h10);
        check("t1_dq", sram_dq, 8'hA5);
        check("t1_oe_setup", sram_oe, 1);
        check("t1_we_setup", sram_we_n, 1);
        tick(1);
        check("t1_we_c3", sram_we_n, 0);
        tick(1);
        check("t1_we_c4", sram_we_n, 0);
        tick(1);                                      // cycle 5: HOLD
        check("t1_we_hold", sram_we_n, 1);
        check("t1_addr_hold", addr, 19'h10);
        tick(1);
        check("t1_addr", addr, 19'h11);
        check("t1_busy_c6", busy, 0);
        check("t1_oe_idle", sram_oe, 0);

        // Test 2: eight back-to-back bytes overflow the 4-deep FIFO
        base = n_log;
        for (int i = 0; i < 8; i++) begin
            data_in = 8'(i + 1); write_in = 1'b1;
            tick(1);
        end
        write_in = 1'b0;
        t = 0;
        while (busy && t < 100) begin
            tick(1);
            t++;
        end
        check("t2_drain_timeout", (t < 100), 1);
        check("t2_nwrites", n_log - base, 5);
        for (int i = 0; i < 5; i++) begin
            check("t2_a", log_a[base + i], 19'h11 + 19'(i));
            check("t2_d", log_d[base + i], exp2[i]);
        end
        check("t2_overrun", overrun, 1);
        check("t2_addr", addr, 19'h16);

        // Test 3: small address space fills at the top address
        ld4 = 1'b1; ldv4 = 4'd14;
        tick(1);
        ld4 = 1'b0;
        check("t3_load", addr4, 14);
        en4 = 1'b1;
        base = n_log4;
        d4 = 8'h11; w4 = 1'b1;                        // cycle 0
        tick(1);
        w4 = 1'b0;
        tick(7);
        d4 = 8'h22; w4 = 1'b1;                        // cycle 8
        tick(1);
        w4 = 1'b0;
        tick(7);
        d4 = 8'h33; w4 = 1'b1;                        // cycle 16
        tick(1);
        w4 = 1'b0;
        check("t3_full", full4, 1);
        check("t3_addr", addr4, 15);
        check("t3_overrun", overrun4, 0);
        check("t3_busy", busy4, 0);
        tick(6);
        check("t3_nwrites", n_log4 - base, 2);
        check("t3_a0", log4_a[base], 14);
        check("t3_d0", log4_d[base], 8'h11);
        check("t3_a1", log4_a[base + 1], 15);
        check("t3_d1", log4_d[base + 1], 8'h22);
        // Load ignored while enabled, honoured once disabled
        ld4 = 1'b1; ldv4 = 4'd3;
        tick(1);
        ld4 = 1'b0;
        check("t5_full_kept", full4, 1);
        check("t5_addr4_kept", addr4, 15);
        en4 = 1'b0;
        ld4 = 1'b1;
        tick(1);
        ld4 = 1'b0;
        check("t5_full_clr", full4, 0);
        check("t5_addr4_load", addr4, 3);

        // Test 4/5: queue four bytes, drop ENABLE mid-strobe, load while busy
        enable = 1'b0;
        addr_load = 1'b1; addr_load_val = 19'h100;
        tick(1);
        addr_load = 1'b0;
        check("t4_load", addr, 19'h100);
        check("t4_overrun_clr", overrun, 0);
        enable = 1'b1;
        base = n_log;
        for (int i = 0; i < 4; i++) begin
            data_in = 8'hB1 + 8'(i); write_in = 1'b1;
            tick(1);
        end
        write_in = 1'b0; enable = 1'b0;               // cycle 4
        check("t4_we_strobe", sram_we_n, 0);
        tick(1);
        data_in = 8'hEE; write_in = 1'b1;             // cycle 5, ignored
        tick(1);
        write_in = 1'b0;                              // cycle 6
        addr_load = 1'b1; addr_load_val = 19'h3000;
        check("t5_addr_c6", addr, 19'h101);
        check("t5_busy_c6", busy, 1);
        tick(1);
        addr_load = 1'b0;
        check("t5_addr_ignored", addr, 19'h101);
        tick(10);                                     // cycle 17: 4th HOLD
        check("t4_busy_c17", busy, 1);
        tick(1);
        check("t4_busy_c18", busy, 0);
        check("t4_nwrites", n_log - base, 4);
        for (int i = 0; i < 4; i++) begin
            check("t4_a", log_a[base + i], 19'h100 + 19'(i));
            check("t4_d", log_d[base + i], 8'hB1 + 8'(i));
        end
        check("t4_addr", addr, 19'h104);
        check("t4_overrun", overrun, 0);
        addr_load = 1'b1;
        tick(1);
        addr_load = 1'b0;
        check("t5_addr_applied", addr, 19'h3000);

        // Test 6: reset during STROBE
        enable = 1'b1;
        data_in = 8'h5A; write_in = 1'b1;             // cycle 0
        tick(1);
        data_in = 8'h5B;                              // cycle 1
        tick(1);
        write_in = 1'b0;
        tick(1);                                      // cycle 3: STROBE
        check("t6_we_strobe", sram_we_n, 0);
        reset = 1'b1;
        #1;
        check("t6_we_async", sram_we_n, 1);
        check("t6_oe_async", sram_oe, 0);
        check("t6_addr", addr, 0);
        check("t6_busy", busy, 0);
        check("t6_sram_a", sram_a, 0);
        tick(1);
        reset = 1'b0;
        tick(6);
        check("t6_busy_after", busy, 0);
        check("t6_we_after", sram_we_n, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
